dec_stream_merger: RTL and testbench



---
 rtl/dec_stream_merger_if.sv | 26 ++
 rtl/dec_stream_merger.sv | 158 +++++++++++++++
 tb/tb_dec_stream_merger.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dec_stream_merger_if.sv
// Bundle of the per-channel decoded byte streams, the merged AXI-Stream byte
// output and the overflow status/clear lines of dec_stream_merger.
interface dec_stream_merger_if #(
  parameter int N_CHS = 1
);
  logic [N_CHS-1:0]    i_vld;
  logic [8*N_CHS-1:0]  i_dec_data;
  logic [N_CHS-1:0]    i_ch_en;
  logic                o_tvalid;
  logic                i_tready;
  logic [7:0]          o_tdata;
  logic [3:0]          o_tuser;
  logic [N_CHS-1:0]    o_fifo_ovf;
  logic [N_CHS-1:0]    i_ovf_clr;
  logic [16*N_CHS-1:0] o_ovf_cnt;

  modport master (
    output i_vld, i_dec_data, i_ch_en, i_tready, i_ovf_clr,
    input  o_tvalid, o_tdata, o_tuser, o_fifo_ovf, o_ovf_cnt
  );

  modport slave (
    input  i_vld, i_dec_data, i_ch_en, i_tready, i_ovf_clr,
    output o_tvalid, o_tdata, o_tuser, o_fifo_ovf, o_ovf_cnt
  );
endinterface

// File: rtl/dec_stream_merger.sv
// Per-channel byte FIFOs merged round-robin into one registered AXI-Stream byte
// stream tagged with the channel index. Define DEC_MERGER_OVF_CNT_EN for dropped-byte counters.
module dec_stream_merger #(
  parameter int N_CHS      = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  dec_stream_merger_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH;

  logic [7:0]       mem    [N_CHS][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr [N_CHS];
  logic [AW-1:0]    rd_ptr [N_CHS];
  logic [AW:0]      count  [N_CHS];
  logic [7:0]       head   [N_CHS];
  logic [N_CHS-1:0] full, nonempty, wr_en, drop, pop;

  logic       grant_vld;
  logic [3:0] grant_idx;
  logic [7:0] grant_data;
  logic [3:0] rr_ptr;
  logic       load;

  logic             tvalid_q;
  logic [7:0]       tdata_q;
  logic [3:0]       tuser_q;
  logic [N_CHS-1:0] ovf_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full     = '0;
    nonempty = '0;
    wr_en    = '0;
    drop     = '0;
    for (int c = 0; c < N_CHS; c++) begin
      full[c]     = (count[c] == CNT_FULL);
      // A disabled channel is being flushed, so it never competes for a grant.
      nonempty[c] = (count[c] != '0) && bus.i_ch_en[c];
      wr_en[c]    = bus.i_vld[c] && bus.i_ch_en[c] && !full[c];
      drop[c]     = bus.i_vld[c] && bus.i_ch_en[c] && full[c];
      head[c]     = mem[c][rd_ptr[c]];
    end
  end

  assign load = !tvalid_q || bus.i_tready;

  // Round-robin: first pass covers rr_ptr..N_CHS-1, second pass wraps to 0.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int c = 0; c < N_CHS; c++) begin
      if (!grant_vld && nonempty[c] && (4'(c) >= rr_ptr)) begin
        grant_vld  = 1'b1;
        grant_idx  = 4'(c);
        grant_data = head[c];
      end
    end
    for (int c = 0; c < N_CHS; c++) begin
      if (!grant_vld && nonempty[c]) begin
        grant_vld  = 1'b1;
        grant_idx  = 4'(c);
        grant_data = head[c];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < N_CHS; c++) begin
      pop[c] = load && grant_vld && (grant_idx == 4'(c));
    end
  end

  // NOTE: the storage array carries no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CHS; c++) begin
      if (wr_en[c]) mem[c][wr_ptr[c]] <= bus.i_dec_data[8*c +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CHS; c++) begin
      if (reset || !bus.i_ch_en[c]) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end else begin
        if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (pop[c])   rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        case ({wr_en[c], pop[c]})
          2'b10:   count[c] <= count[c] + CNT_ONE;
          2'b01:   count[c] <= count[c] - CNT_ONE;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      if (grant_vld) begin
        tvalid_q <= 1'b1;
        tdata_q  <= grant_data;
        tuser_q  <= grant_idx;
        rr_ptr   <= (grant_idx == 4'(N_CHS - 1)) ? 4'd0 : grant_idx + 4'd1;
      end else begin
        tvalid_q <= 1'b0;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CHS; c++) begin
      if (reset)                 ovf_q[c] <= 1'b0;
      else if (drop[c])          ovf_q[c] <= 1'b1;
      else if (bus.i_ovf_clr[c]) ovf_q[c] <= 1'b0;
    end
  end

`ifdef DEC_MERGER_OVF_CNT_EN
  logic [15:0] ovf_cnt [N_CHS];

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CHS; c++) begin
      if (reset)                 ovf_cnt[c] <= '0;
      else if (drop[c])          ovf_cnt[c] <= bus.i_ovf_clr[c] ? 16'd1 :
                                               (ovf_cnt[c] == 16'hFFFF) ? 16'hFFFF : ovf_cnt[c] + 16'd1;
      else if (bus.i_ovf_clr[c]) ovf_cnt[c] <= '0;
    end
  end

  always_comb begin
    bus.o_ovf_cnt = '0;
    for (int c = 0; c < N_CHS; c++) begin
      bus.o_ovf_cnt[16*c +: 16] = ovf_cnt[c];
    end
  end
`else
  assign bus.o_ovf_cnt = '0;
`endif

  assign bus.o_tvalid   = tvalid_q;
  assign bus.o_tdata    = tdata_q;
  assign bus.o_tuser    = tuser_q;
  assign bus.o_fifo_ovf = ovf_q;
endmodule

// File: tb/tb_dec_stream_merger.sv
// Scoreboard bench for dec_stream_merger (4 channels, 16-deep FIFOs): expected
// {tuser,tdata} beats are queued at stimulus time and compared on each transfer.
module tb_dec_stream_merger;
  localparam int N_CHS = 4;
  localparam int FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic mon_en;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [11:0] sb [$];
  logic [11:0] mon_exp;

  dec_stream_merger_if #(.N_CHS(N_CHS)) bus ();

  dec_stream_merger #(.N_CHS(N_CHS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Transfers happen on the rising edge; sample the handshake on the falling edge.
  always @(negedge clk) begin
    if (mon_en && bus.o_tvalid && bus.i_tready) begin
      if (sb.size() == 0) begin
        check("spurious_beat", 32'(bus.o_tvalid), 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("beat_tdata", 32'(bus.o_tdata), 32'(mon_exp[7:0]));
        check("beat_tuser", 32'(bus.o_tuser), 32'(mon_exp[11:8]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    mon_en         = 1'b0;
    bus.i_vld      = '0;
    bus.i_dec_data = '0;
    bus.i_ch_en    = '1;
    bus.i_tready   = 1'b0;
    bus.i_ovf_clr  = '0;
    repeat (2) tick();

    check("rst_tvalid", 32'(bus.o_tvalid), 32'd0);
    check("rst_tdata", 32'(bus.o_tdata), 32'd0);
    check("rst_tuser", 32'(bus.o_tuser), 32'd0);
    check("rst_ovf", 32'(bus.o_fifo_ovf), 32'd0);
    check("rst_ovf_cnt", bus.o_ovf_cnt[31:0], 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Simultaneous arrivals on all channels, rr_ptr starts at 0.
    bus.i_tready   = 1'b1;
    bus.i_vld      = 4'hF;
    bus.i_dec_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 4; c++) sb.push_back({4'(c), 8'(8'h10 + c)});
    tick();
    bus.i_vld = '0;
    tick();
    for (int b = 0; b < 4; b++) begin
      check("burst_valid", 32'(bus.o_tvalid), 32'd1);
      tick();
    end
    check("burst_end", 32'(bus.o_tvalid), 32'd0);

    // Single byte on channel 2: visible after edge k+1 for exactly one cycle.
    bus.i_vld              = 4'b0100;
    bus.i_dec_data         = '0;
    bus.i_dec_data[23:16]  = 8'hA5;
    sb.push_back({4'd2, 8'hA5});
    tick();
    bus.i_vld = '0;
    check("single_latency", 32'(bus.o_tvalid), 32'd0);
    tick();
    check("single_valid", 32'(bus.o_tvalid), 32'd1);
    check("single_tdata", 32'(bus.o_tdata), 32'hA5);
    check("single_tuser", 32'(bus.o_tuser), 32'd2);
    tick();
    check("single_one_cycle", 32'(bus.o_tvalid), 32'd0);

    // Fairness: channels 0 and 3 every cycle; rr_ptr is 3 here, so ch3 leads.
    for (int i = 0; i < 20; i++) begin
      bus.i_vld      = 4'b1001;
      bus.i_dec_data = {8'(8'h80 + i), 16'h0000, 8'(i)};
      sb.push_back({4'd3, 8'(8'h80 + i)});
      sb.push_back({4'd0, 8'(i)});
      tick();
    end
    bus.i_vld = '0;
    wait_drain("fair_drain", 60);
    check("fair_no_ovf", 32'(bus.o_fifo_ovf), 32'd0);

    // Backpressure: 20 bytes into channel 1 with the sink stalled; 17 fit.
    bus.i_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.i_vld             = 4'b0010;
      bus.i_dec_data        = '0;
      bus.i_dec_data[15:8]  = 8'(i);
      if (i <= FIFO_DEPTH) sb.push_back({4'd1, 8'(i)});
      tick();
      check("ovf_timing", 32'(bus.o_fifo_ovf[1]), 32'(i >= 17));
      if (i >= 1) begin
        check("bp_hold_valid", 32'(bus.o_tvalid), 32'd1);
        check("bp_hold_tdata", 32'(bus.o_tdata), 32'd0);
        check("bp_hold_tuser", 32'(bus.o_tuser), 32'd1);
      end
    end
    bus.i_vld = '0;
    check("ovf_other_chs", 32'(bus.o_fifo_ovf & 4'b1101), 32'd0);
`ifdef DEC_MERGER_OVF_CNT_EN
    check("ovf_cnt_ch1", 32'(bus.o_ovf_cnt[31:16]), 32'd3);
`else
    check("ovf_cnt_ch1", 32'(bus.o_ovf_cnt[31:16]), 32'd0);
`endif
    bus.i_tready = 1'b1;
    wait_drain("bp_drain", 40);
    tick();
    check("bp_end_idle", 32'(bus.o_tvalid), 32'd0);
    check("ovf_sticky", 32'(bus.o_fifo_ovf[1]), 32'd1);
    bus.i_ovf_clr = 4'b0010;
    tick();
    bus.i_ovf_clr = '0;
    check("ovf_clr_flag", 32'(bus.o_fifo_ovf[1]), 32'd0);
    check("ovf_clr_cnt", 32'(bus.o_ovf_cnt[31:16]), 32'd0);

    // Disable mid-stream: only the byte already in the output register survives.
    bus.i_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_vld            = 4'b0001;
      bus.i_dec_data       = '0;
      bus.i_dec_data[7:0]  = 8'(8'h50 + i);
      if (i == 0) sb.push_back({4'd0, 8'h50});
      tick();
    end
    bus.i_vld = '0;
    tick();
    bus.i_ch_en = 4'b1110;
    tick();
    bus.i_ch_en  = '1;
    bus.i_tready = 1'b1;
    wait_drain("dis_drain", 10);
    repeat (3) begin
      tick();
      check("dis_flushed", 32'(bus.o_tvalid), 32'd0);
    end
    check("dis_no_ovf", 32'(bus.o_fifo_ovf), 32'd0);

    // Reset mid-transfer with a held byte and non-empty FIFOs; rr_ptr becomes 2.
    bus.i_tready   = 1'b0;
    bus.i_vld      = 4'b0110;
    bus.i_dec_data = {8'h00, 8'hB2, 8'hB1, 8'h00};
    repeat (3) tick();
    bus.i_vld = '0;
    check("pre_reset_valid", 32'(bus.o_tvalid), 32'd1);
    reset  = 1'b1;
    mon_en = 1'b0;
    sb.delete();
    tick();
    reset = 1'b0;
    check("mid_rst_tvalid", 32'(bus.o_tvalid), 32'd0);
    check("mid_rst_tdata", 32'(bus.o_tdata), 32'd0);
    check("mid_rst_tuser", 32'(bus.o_tuser), 32'd0);
    check("mid_rst_ovf", 32'(bus.o_fifo_ovf), 32'd0);
    mon_en       = 1'b1;
    bus.i_tready = 1'b1;
    repeat (5) begin
      tick();
      check("post_reset_idle", 32'(bus.o_tvalid), 32'd0);
    end
    bus.i_vld      = 4'b1001;
    bus.i_dec_data = {8'hC3, 16'h0000, 8'hC0};
    sb.push_back({4'd0, 8'hC0});
    sb.push_back({4'd3, 8'hC3});
    tick();
    bus.i_vld = '0;
    tick();
    check("first_grant_valid", 32'(bus.o_tvalid), 32'd1);
    check("first_grant_tuser", 32'(bus.o_tuser), 32'd0);
    wait_drain("post_reset_drain", 10);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
